// File: rtl/led_frame_writer_pkg.sv
// Shared types for the LED frame writer: command opcodes, pixel colours and FSM states.
package led_frame_pkg;

  typedef enum logic [1:0] {
    OP_PIXEL = 2'd0,
    OP_ROW   = 2'd1,
    OP_CLEAR = 2'd2,
    OP_SWAP  = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    ORANGE = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    WAIT_SYNC = 2'd2
  } state_t;

  // Returns {green, red}; ORANGE lights both LEDs of the pixel.
  function automatic logic [1:0] color_bits(color_t c);
    logic [1:0] v;
    v = c;
    return {v[1], v[0]};
  endfunction

endpackage

// File: rtl/led_frame_writer_if.sv
// Command port of the frame writer: game logic (master) to frame writer (slave).
// Handshake: a command transfers on a rising clk edge where cmd_valid and cmd_ready are both high;
// cmd_op and its operand fields are only meaningful while cmd_valid is high.
interface led_frame_writer_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  import led_frame_pkg::*;

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic              cmd_valid;
  logic              cmd_ready;
  cmd_op_t           cmd_op;
  logic [RW-1:0]     cmd_row;
  logic [CW-1:0]     cmd_col;
  color_t            cmd_color;
  logic [2*COLS-1:0] cmd_rowdata;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_color, cmd_rowdata,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_color, cmd_rowdata,
    output cmd_ready
  );

endinterface

// File: rtl/increment.sv
// Generic +1 helper shared across the codebase.
module increment #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = in_i + WIDTH'(1);

endmodule

// File: rtl/led_frame_writer.sv
// Double-buffered red/green frame store for the 8x8 bi-colour matrix; the front buffer
// only reloads from the back buffer on a scan-frame boundary after a swap request.
module led_frame_writer
  import led_frame_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  led_frame_writer_if.slave          cmd,
  input  logic                       frame_sync,
  output logic [ROWS-1:0][COLS-1:0]  red_array,
  output logic [ROWS-1:0][COLS-1:0]  green_array,
  output logic                       swap_done,
  output state_t                     dbg_state_o
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW:0]   ROW_LIM  = (RW + 1)'(ROWS);
  localparam logic [CW:0]   COL_LIM  = (CW + 1)'(COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t                    state_q, state_d;
  logic [RW-1:0]             clr_row_q, clr_row_d, clr_row_inc;
  logic [ROWS-1:0][COLS-1:0] back_red_q, back_red_d;
  logic [ROWS-1:0][COLS-1:0] back_green_q, back_green_d;
  logic [ROWS-1:0][COLS-1:0] front_red_q, front_red_d;
  logic [ROWS-1:0][COLS-1:0] front_green_q, front_green_d;
  logic                      swap_done_q, swap_done_d;
  logic                      accept;
  logic                      row_ok, col_ok;
  logic [1:0]                pix;

  increment #(.WIDTH(RW)) u_clr_inc (
    .in_i  (clr_row_q),
    .out_o (clr_row_inc)
  );

  always_comb begin
    state_d       = state_q;
    clr_row_d     = clr_row_q;
    back_red_d    = back_red_q;
    back_green_d  = back_green_q;
    front_red_d   = front_red_q;
    front_green_d = front_green_q;
    swap_done_d   = 1'b0;
    cmd.cmd_ready = (state_q == IDLE);
    accept        = cmd.cmd_valid & cmd.cmd_ready;
    // Non-power-of-2 geometries can address past the end; such writes are silently dropped.
    row_ok        = ({1'b0, cmd.cmd_row} < ROW_LIM);
    col_ok        = ({1'b0, cmd.cmd_col} < COL_LIM);
    pix           = color_bits(cmd.cmd_color);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (cmd.cmd_op)
            OP_PIXEL: begin
              if (row_ok && col_ok) begin
                back_red_d[cmd.cmd_row][cmd.cmd_col]   = pix[0];
                back_green_d[cmd.cmd_row][cmd.cmd_col] = pix[1];
              end
            end
            OP_ROW: begin
              if (row_ok) begin
                back_red_d[cmd.cmd_row]   = cmd.cmd_rowdata[COLS-1:0];
                back_green_d[cmd.cmd_row] = cmd.cmd_rowdata[2*COLS-1:COLS];
              end
            end
            OP_CLEAR: begin
              state_d   = CLEAR;
              clr_row_d = '0;
            end
            OP_SWAP: state_d = WAIT_SYNC;
            default: ;
          endcase
        end
      end
      CLEAR: begin
        back_red_d[clr_row_q]   = '0;
        back_green_d[clr_row_q] = '0;
        clr_row_d               = clr_row_inc;
        if (clr_row_q == LAST_ROW) state_d = IDLE;
      end
      WAIT_SYNC: begin
        // The sync seen in the accept cycle never reaches here, so the earliest swap is the next one.
        if (frame_sync) begin
          front_red_d   = back_red_q;
          front_green_d = back_green_q;
          swap_done_d   = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      clr_row_q     <= '0;
      back_red_q    <= '0;
      back_green_q  <= '0;
      front_red_q   <= '0;
      front_green_q <= '0;
      swap_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_row_q     <= clr_row_d;
      back_red_q    <= back_red_d;
      back_green_q  <= back_green_d;
      front_red_q   <= front_red_d;
      front_green_q <= front_green_d;
      swap_done_q   <= swap_done_d;
    end
  end

  assign red_array   = front_red_q;
  assign green_array = front_green_q;
  assign swap_done   = swap_done_q;
  assign dbg_state_o = state_q;

endmodule
